vend_seq: RTL

VEND_SEQ -- requirements
Module: vend_seq

---
 rtl/vend_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vend_seq.sv
// rtl/vend_seq.sv - vending machine control sequencer (IDLE/COLLECT/VEND/REFUND/SERVICE)
// Idle-timeout auto-refund is built only when VEND_TIMEOUT_EN is defined.
module vend_seq #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inserted,
  input  logic       selected,
  input  logic       overpaid,
  input  logic       selReq,
  input  logic       cancel,
  input  logic       service,
  input  logic       priceStb,
  output logic       ldPayment,
  output logic       ldSelect,
  output logic       ldPrice,
  output logic       refund,
  output logic       timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_REFUND  = 3'd3,
    S_SERVICE = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   ld_select_q, ld_select_d;
  logic   refund_q, refund_d;
  logic   timeout_q, timeout_d;
  logic   to_hit;

`ifdef VEND_TIMEOUT_EN
  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;

  // Counter only runs in COLLECT; outside it stays at zero so entry starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_COLLECT || inserted) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign to_hit = (cnt_q == CNT_MAX);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_hit         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (service) begin
          state_d = S_SERVICE;
        end else if (inserted) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (overpaid || cancel) begin
          state_d = S_REFUND;
        end else if (to_hit) begin
          state_d   = S_REFUND;
          timeout_d = 1'b1;
        end else if (selReq && selected) begin
          state_d = S_VEND;
        end
      end
      S_VEND:    state_d = S_IDLE;
      S_REFUND:  state_d = S_IDLE;
      S_SERVICE: begin
        if (!service) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
    // Moore pulses are registered alongside the state they belong to.
    ld_select_d = (state_d == S_VEND);
    refund_d    = (state_d == S_REFUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ld_select_q <= 1'b0;
      refund_q    <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ld_select_q <= ld_select_d;
      refund_q    <= refund_d;
      timeout_q   <= timeout_d;
`ifdef VEND_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Reset forces every output low in the same cycle, aborting any pulse in flight.
  assign ldPayment = ~rst & inserted & ~overpaid &
                     ((state_q == S_IDLE) | (state_q == S_COLLECT));
  assign ldPrice   = ~rst & priceStb & (state_q == S_SERVICE);
  assign ldSelect  = ~rst & ld_select_q;
  assign refund    = ~rst & refund_q;
  assign timeout   = ~rst & timeout_q;
  assign state     = rst ? 3'd0 : state_q;

endmodule
